// File: rtl/bluemax_pio_pkg.sv
// Shared definitions for the bluemax PIO slaves.
//   ADDR_*      : Avalon-MM word addresses of the PIO registers
//   edge_type_e : encodings accepted by the EDGE_TYPE parameter
package bluemax_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum int unsigned {
        EDGE_RISING  = 0,
        EDGE_FALLING = 1,
        EDGE_ANY     = 2
    } edge_type_e;

endpackage

// File: rtl/bluemax_pio_debounce_bit.sv
// Single-bit input conditioner: two-flop synchronizer, optionally followed
// by a stability counter that only accepts a level once it has held for
// DEBOUNCE_CYCLES consecutive cycles.
// Optional feature macro: BLUEMAX_BUTTON_PIO_DEBOUNCE_EN (counter only built
// when defined; otherwise cond_bit is the synchronizer output).
// Ports:
//   clk      : system clock
//   reset    : asynchronous, active-high reset (flops load IDLE_LEVEL)
//   in_bit   : asynchronous external input
//   cond_bit : conditioned level in the clk domain
module bluemax_pio_debounce_bit #(
    parameter bit          IDLE_LEVEL      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic cond_bit
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

`ifdef BLUEMAX_BUTTON_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             deb;

    // Any return to the accepted level restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES never changes deb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            deb <= IDLE_LEVEL;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cond_bit = deb;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign cond_bit = sync2;
`endif

endmodule

// File: rtl/bluemax_platform_button_pio.sv
// Input-direction Avalon-MM PIO slave for buttons/switches.
// Synchronizes in_port, exposes its live level (DATA), latches selected
// edges into a sticky write-1-to-clear EDGECAPTURE register and raises a
// registered, maskable level interrupt.
// Optional feature macro: BLUEMAX_BUTTON_PIO_DEBOUNCE_EN (per-bit debounce).
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   address    : register word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (bits above WIDTH ignored)
//   in_port    : asynchronous external inputs
//   readdata   : zero-latency, zero-extended read data
//   irq        : active-high level interrupt
module bluemax_platform_button_pio
    import bluemax_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IDLE_LEVEL      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam bit         IDLE_BIT = (IDLE_LEVEL != 0);
    localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE);

    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] wd;
    logic             wr;
    logic             wr_mask;
    logic             wr_cap;
    logic             irq_q;
    logic             unused_writedata_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bluemax_pio_debounce_bit #(
            .IDLE_LEVEL      (IDLE_BIT),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .in_bit   (in_port[i]),
            .cond_bit (cond[i])
        );
    end

    // History starts at the idle level so reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= {WIDTH{IDLE_BIT}};
        else       prev <= cond;
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_SEL)
            EDGE_FALLING: edge_hit = ~cond & prev;
            EDGE_ANY:     edge_hit = cond ^ prev;
            default:      edge_hit = cond & ~prev;
        endcase
    end

    assign wr      = chipselect & ~write_n;
    assign wr_mask = wr && (address == ADDR_IRQMASK);
    assign wr_cap  = wr && (address == ADDR_EDGECAP);
    assign wd      = writedata[WIDTH-1:0];

    assign unused_writedata_bits = ^{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        irqmask <= '0;
        else if (wr_mask) irqmask <= wd;
    end

    // A new edge in the same cycle as a clear write keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) edgecap <= '0;
        else       edgecap <= edge_hit | (edgecap & ~(wr_cap ? wd : '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |(edgecap & irqmask);
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = cond;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

endmodule
